// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Registers the EX->MEM bus and load decode, tracks outstanding load data
// with a three-state FSM (idle / waiting for data / data buffered), and
// produces the write-back and forwarding buses combinationally.
// Build option: define MEM_FWD_EN to drive mem_to_rf_bus with the write-back
// triple; otherwise mem_to_rf_bus is tied to zero.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [75:0] ex_to_mem_bus,
  input  logic [4:0]  ex_load_bus,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_rvalid,
  output logic [69:0] mem_to_wb_bus,
  output logic [37:0] mem_to_rf_bus,
  output logic        stallreq_for_mem
);

  localparam logic STOP = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HAVE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [75:0] ex_bus_p1;
  logic [4:0]  load_p1;
  logic [31:0] rdata_buf;
  logic        reg_load, reg_clear, is_load_in, capture_en;
  logic        unused_stall_bits;

  // Load-result extraction: pick byte/half by address, then sign/zero extend.
  function automatic logic [31:0] load_ext(input logic [4:0]  ld,
                                           input logic [1:0]  a,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    r = '0;
    if (ld[4])      r = {{24{b[7]}}, b};
    else if (ld[3]) r = {24'd0, b};
    else if (ld[2]) r = {{16{h[15]}}, h};
    else if (ld[1]) r = {16'd0, h};
    else if (ld[0]) r = w;
    return r;
  endfunction

  assign reg_load   = (stall[3] != STOP);
  assign reg_clear  = (stall[3] == STOP) && (stall[4] != STOP);
  assign is_load_in = ex_to_mem_bus[43] && (ex_to_mem_bus[42:39] == 4'd0) &&
                      (|ex_load_bus);
  assign capture_en = (state == ST_WAIT) && data_sram_rvalid && (stall[4] == STOP);
  assign unused_stall_bits = ^{stall[5], stall[2:0]};

  // ---- EX->MEM boundary: input register (bubble on clear, hold on stall) ----
  always_ff @(posedge clk) begin
    if (rst || reg_clear) begin
      ex_bus_p1 <= '0;
      load_p1   <= '0;
    end else if (reg_load) begin
      ex_bus_p1 <= ex_to_mem_bus;
      load_p1   <= ex_load_bus;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: a register reload/clear always re-decides the state
  always_comb begin
    state_nxt = state;
    if (reg_clear)
      state_nxt = ST_IDLE;
    else if (reg_load)
      state_nxt = is_load_in ? ST_WAIT : ST_IDLE;
    else if (capture_en)
      state_nxt = ST_HAVE;
  end

  // Hold read data that arrived while the next stage was stalled
  always_ff @(posedge clk) begin
    if (rst)             rdata_buf <= '0;
    else if (capture_en) rdata_buf <= data_sram_rdata;
  end

  logic [31:0] pc_p1, ex_result_p1, load_word, load_res, rf_wdata;
  logic [4:0]  rf_waddr_p1;
  logic        sel_rf_res_p1, rf_we_p1, rf_we_out, data_missing;

  assign pc_p1         = ex_bus_p1[75:44];
  assign sel_rf_res_p1 = ex_bus_p1[38];
  assign rf_we_p1      = ex_bus_p1[37];
  assign rf_waddr_p1   = ex_bus_p1[36:32];
  assign ex_result_p1  = ex_bus_p1[31:0];

  // Output formation: select load data source and gate write enable
  always_comb begin
    data_missing = (state == ST_WAIT) && !data_sram_rvalid;
    load_word    = (state == ST_HAVE) ? rdata_buf : data_sram_rdata;
    load_res     = load_ext(load_p1, ex_result_p1[1:0], load_word);
    rf_wdata     = ((state != ST_IDLE) && sel_rf_res_p1) ? load_res : ex_result_p1;
    rf_we_out    = rf_we_p1 && !data_missing;
  end

  assign stallreq_for_mem = data_missing;
  assign mem_to_wb_bus    = {pc_p1, rf_we_out, rf_waddr_p1, rf_wdata};

`ifdef MEM_FWD_EN
  assign mem_to_rf_bus = {rf_we_out, rf_waddr_p1, rf_wdata};
`else
  assign mem_to_rf_bus = '0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_to_mem_bus;
  logic [4:0]  ex_load_bus;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_rf_bus;
  logic        stallreq_for_mem;

  int total = 0;
  int bad   = 0;
  logic [69:0] exp_wb;

  localparam logic [5:0] HOLD   = 6'b011111;
  localparam logic [5:0] BUBBLE = 6'b001111;
  localparam logic [4:0] LB = 5'b10000, LBU = 5'b01000, LH = 5'b00100,
                         LHU = 5'b00010, LW = 5'b00001;

  mem_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_to_mem_bus    (ex_to_mem_bus),
    .ex_load_bus      (ex_load_bus),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .mem_to_wb_bus    (mem_to_wb_bus),
    .mem_to_rf_bus    (mem_to_rf_bus),
    .stallreq_for_mem (stallreq_for_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] mk(input logic [31:0] pc, input logic en,
                                     input logic [3:0] wen, input logic sel,
                                     input logic we, input logic [4:0] wa,
                                     input logic [31:0] res);
    return {pc, en, wen, sel, we, wa, res};
  endfunction

  function automatic logic [69:0] wb(input logic [31:0] pc, input logic we,
                                     input logic [4:0] wa, input logic [31:0] d);
    return {pc, we, wa, d};
  endfunction

  function automatic logic [37:0] rfx(input logic [69:0] w);
`ifdef MEM_FWD_EN
    return w[37:0];
`else
    return 38'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_to_mem_bus = '0; ex_load_bus = '0; stall = '0;
    data_sram_rvalid = 1'b0; data_sram_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_to_mem_bus = mk(32'hDEAD_0000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd3, 32'h44);
    ex_load_bus = LW; stall = '0;
    data_sram_rvalid = 1'b1; data_sram_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    total++; if (mem_to_wb_bus !== 70'd0) begin bad++;
      $display("FAIL reset_wb got=%h want=0", mem_to_wb_bus); end
    total++; if (mem_to_rf_bus !== 38'd0) begin bad++;
      $display("FAIL reset_rf got=%h want=0", mem_to_rf_bus); end
    total++; if (stallreq_for_mem !== 1'b0) begin bad++;
      $display("FAIL reset_stallreq got=%b want=0", stallreq_for_mem); end
    tick();
  endtask

  task automatic test_lw_same_cycle();
    ex_to_mem_bus = mk(32'h0000_1000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd5, 32'h100);
    ex_load_bus = LW; stall = '0;
    data_sram_rvalid = 1'b1; data_sram_rdata = 32'h8765_4321;
    tick();
    ex_to_mem_bus = '0; ex_load_bus = '0;
    @(negedge clk);
    exp_wb = wb(32'h0000_1000, 1'b1, 5'd5, 32'h8765_4321);
    total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
      $display("FAIL lw_same_wb got=%h want=%h", mem_to_wb_bus, exp_wb); end
    total++; if (mem_to_rf_bus !== rfx(exp_wb)) begin bad++;
      $display("FAIL lw_same_rf got=%h want=%h", mem_to_rf_bus, rfx(exp_wb)); end
    total++; if (stallreq_for_mem !== 1'b0) begin bad++;
      $display("FAIL lw_same_stallreq got=%b want=0", stallreq_for_mem); end
    tick();
    idle_inputs();
  endtask

  task automatic test_byte_half();
    logic [4:0]  t_ld [6] = '{LB, LBU, LH, LHU, LB, LW};
    logic [31:0] t_ad [6] = '{32'h203, 32'h203, 32'h202, 32'h201, 32'h201, 32'h103};
    logic [31:0] t_rd [6] = '{32'h8012_3456, 32'h8012_3456, 32'h8001_0000,
                              32'h1234_ABCD, 32'h0000_7F00, 32'hA5A5_5A5A};
    logic [31:0] t_ex [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001,
                              32'h0000_ABCD, 32'h0000_007F, 32'hA5A5_5A5A};
    for (int i = 0; i < 6; i++) begin
      ex_to_mem_bus = mk(32'h3000 + 32'(i * 4), 1'b1, 4'd0, 1'b1, 1'b1,
                         5'(i + 1), t_ad[i]);
      ex_load_bus = t_ld[i]; stall = '0;
      data_sram_rvalid = 1'b1; data_sram_rdata = t_rd[i];
      tick();
      ex_to_mem_bus = '0; ex_load_bus = '0;
      @(negedge clk);
      exp_wb = wb(32'h3000 + 32'(i * 4), 1'b1, 5'(i + 1), t_ex[i]);
      total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
        $display("FAIL ext_%0d_wb got=%h want=%h", i, mem_to_wb_bus, exp_wb); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lw_delayed();
    ex_to_mem_bus = mk(32'h0000_4000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd8, 32'h200);
    ex_load_bus = LW; stall = '0; data_sram_rvalid = 1'b0;
    tick();
    stall = HOLD; ex_to_mem_bus = '0; ex_load_bus = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (stallreq_for_mem !== 1'b1) begin bad++;
        $display("FAIL wait_%0d_stallreq got=%b want=1", k, stallreq_for_mem); end
      total++; if (mem_to_wb_bus[37] !== 1'b0) begin bad++;
        $display("FAIL wait_%0d_we got=%b want=0", k, mem_to_wb_bus[37]); end
      tick();
    end
    stall = '0; data_sram_rvalid = 1'b1; data_sram_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    exp_wb = wb(32'h0000_4000, 1'b1, 5'd8, 32'h0BAD_CAFE);
    total++; if (stallreq_for_mem !== 1'b0) begin bad++;
      $display("FAIL delayed_stallreq got=%b want=0", stallreq_for_mem); end
    total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
      $display("FAIL delayed_wb got=%h want=%h", mem_to_wb_bus, exp_wb); end
    tick();
    idle_inputs();
  endtask

  task automatic test_have_capture();
    logic [31:0] rd_seq [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    logic        rv_seq [3] = '{1'b0, 1'b1, 1'b0};
    ex_to_mem_bus = mk(32'h0000_6000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h300);
    ex_load_bus = LW; stall = '0; data_sram_rvalid = 1'b0;
    tick();
    ex_to_mem_bus = '0; ex_load_bus = '0;
    stall = HOLD; data_sram_rvalid = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    exp_wb = wb(32'h0000_6000, 1'b1, 5'd9, 32'hCAFE_F00D);
    @(negedge clk);
    total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
      $display("FAIL cap_arrive_wb got=%h want=%h", mem_to_wb_bus, exp_wb); end
    tick();
    for (int k = 0; k < 3; k++) begin
      data_sram_rvalid = rv_seq[k]; data_sram_rdata = rd_seq[k];
      if (k == 2) stall = '0;
      @(negedge clk);
      total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
        $display("FAIL have_%0d_wb got=%h want=%h", k, mem_to_wb_bus, exp_wb); end
      total++; if (stallreq_for_mem !== 1'b0) begin bad++;
        $display("FAIL have_%0d_stallreq got=%b want=0", k, stallreq_for_mem); end
      tick();
    end
    @(negedge clk);
    total++; if (mem_to_wb_bus !== 70'd0) begin bad++;
      $display("FAIL have_exit_wb got=%h want=0", mem_to_wb_bus); end
    tick();
    idle_inputs();
  endtask

  task automatic test_bubble();
    ex_to_mem_bus = mk(32'h0000_2000, 1'b0, 4'd0, 1'b0, 1'b1, 5'd7, 32'h1234_5678);
    ex_load_bus = '0; stall = '0;
    tick();
    ex_to_mem_bus = mk(32'h0000_2004, 1'b0, 4'd0, 1'b0, 1'b1, 5'd6, 32'h0F0F_0F0F);
    stall = HOLD;
    exp_wb = wb(32'h0000_2000, 1'b1, 5'd7, 32'h1234_5678);
    @(negedge clk);
    total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
      $display("FAIL alu_wb got=%h want=%h", mem_to_wb_bus, exp_wb); end
    total++; if (mem_to_rf_bus !== rfx(exp_wb)) begin bad++;
      $display("FAIL alu_rf got=%h want=%h", mem_to_rf_bus, rfx(exp_wb)); end
    tick();
    stall = BUBBLE;
    @(negedge clk);
    total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
      $display("FAIL hold_wb got=%h want=%h", mem_to_wb_bus, exp_wb); end
    tick();
    @(negedge clk);
    total++; if (mem_to_wb_bus !== 70'd0) begin bad++;
      $display("FAIL bubble_wb got=%h want=0", mem_to_wb_bus); end
    total++; if (mem_to_rf_bus !== 38'd0) begin bad++;
      $display("FAIL bubble_rf got=%h want=0", mem_to_rf_bus); end
    // store carrying a stray load bit must not wait for data
    stall = '0;
    ex_to_mem_bus = mk(32'h0000_5000, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h400);
    ex_load_bus = LW; data_sram_rvalid = 1'b0;
    tick();
    ex_to_mem_bus = '0; ex_load_bus = '0;
    exp_wb = wb(32'h0000_5000, 1'b0, 5'd0, 32'h400);
    @(negedge clk);
    total++; if (stallreq_for_mem !== 1'b0) begin bad++;
      $display("FAIL store_stallreq got=%b want=0", stallreq_for_mem); end
    total++; if (mem_to_wb_bus !== exp_wb) begin bad++;
      $display("FAIL store_wb got=%h want=%h", mem_to_wb_bus, exp_wb); end
    tick();
    idle_inputs();
  endtask

  task automatic test_rst_mid_wait();
    ex_to_mem_bus = mk(32'h0000_7000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd11, 32'h500);
    ex_load_bus = LW; stall = '0; data_sram_rvalid = 1'b0;
    tick();
    ex_to_mem_bus = '0; ex_load_bus = '0; stall = HOLD;
    @(negedge clk);
    total++; if (stallreq_for_mem !== 1'b1) begin bad++;
      $display("FAIL rstwait_pre got=%b want=1", stallreq_for_mem); end
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = '0;
    data_sram_rvalid = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (mem_to_wb_bus !== 70'd0) begin bad++;
        $display("FAIL rstwait_%0d_wb got=%h want=0", k, mem_to_wb_bus); end
      total++; if (mem_to_rf_bus !== 38'd0) begin bad++;
        $display("FAIL rstwait_%0d_rf got=%h want=0", k, mem_to_rf_bus); end
      total++; if (stallreq_for_mem !== 1'b0) begin bad++;
        $display("FAIL rstwait_%0d_stallreq got=%b want=0", k, stallreq_for_mem); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_lw_same_cycle();
    test_byte_half();
    test_lw_delayed();
    test_have_capture();
    test_bubble();
    test_rst_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
